// File: rtl/prefetch_queue_if.sv
// Signal bundle between the prefetch queue, the memory bus and the decoder.
// Handshake: bus_req/bus_addr are held stable until bus_ack; bus_data is valid only in the ack cycle.
interface prefetch_queue_if;
  logic        flush;
  logic [23:0] flush_pc;
  logic        bus_req;
  logic [23:0] bus_addr;
  logic        bus_ack;
  logic [15:0] bus_data;
  logic [1:0]  consume;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] ext;
  logic        ext_valid;
  logic [23:0] inst_pc;
  logic        addr_err;

  modport master (
    output flush, flush_pc, bus_ack, bus_data, consume,
    input  bus_req, bus_addr, inst, inst_valid, ext, ext_valid, inst_pc, addr_err
  );

  modport slave (
    input  flush, flush_pc, bus_ack, bus_data, consume,
    output bus_req, bus_addr, inst, inst_valid, ext, ext_valid, inst_pc, addr_err
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words from a single-request bus and
// presents the head word and its successor to the decoder.
module prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_L,
  prefetch_queue_if.slave              bus,
  output logic [1:0]                   o_state,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, ERR = 2'd3} state_t;

  state_t        r_state, w_state_nx;
  logic          r_bus_req, w_req_nx;
  logic [23:0]   r_bus_addr, w_addr_nx;
  logic          r_pend_err, w_pend_nx;
  logic          r_fetch_en;
  logic [23:0]   r_fetch_pc;
  logic [23:0]   r_inst_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [15:0]   r_mem [DEPTH];
  logic          r_addr_err;

  logic          w_odd;
  logic          w_ack_acc;
  logic          w_cons_ok;
  logic [1:0]    w_cons_amt;
  logic [PW-1:0] w_ext_ptr;

  assign w_odd      = bus.flush_pc[0];
  // Flush wins over a same-cycle ack; acks in DRAIN belong to a discarded request.
  assign w_ack_acc  = bus.bus_ack && (r_state == FETCH) && !bus.flush;
  assign w_cons_ok  = (bus.consume != 2'd3) && (CW'(bus.consume) <= r_count);
  assign w_cons_amt = w_cons_ok ? bus.consume : 2'd0;
  assign w_ext_ptr  = r_rd_ptr + PW'(1);

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_bus_req;
    w_addr_nx  = r_bus_addr;
    w_pend_nx  = r_pend_err;
    case (r_state)
      IDLE: begin
        if (bus.flush) begin
          w_state_nx = w_odd ? ERR : IDLE;
        end else if (r_fetch_en && (r_count < CW'(DEPTH))) begin
          w_state_nx = FETCH;
          w_req_nx   = 1'b1;
          w_addr_nx  = r_fetch_pc;
        end
      end
      FETCH: begin
        if (bus.bus_ack) begin
          w_req_nx   = 1'b0;
          w_state_nx = (bus.flush && w_odd) ? ERR : IDLE;
        end else if (bus.flush) begin
          w_state_nx = DRAIN;
          w_pend_nx  = w_odd;
        end
      end
      DRAIN: begin
        if (bus.bus_ack) begin
          w_req_nx = 1'b0;
          if (bus.flush) w_state_nx = w_odd ? ERR : IDLE;
          else           w_state_nx = r_pend_err ? ERR : IDLE;
        end else if (bus.flush) begin
          w_pend_nx = w_odd;
        end
      end
      ERR: begin
        if (bus.flush && !w_odd) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_state    <= IDLE;
      r_bus_req  <= 1'b0;
      r_bus_addr <= '0;
      r_pend_err <= 1'b0;
      r_fetch_en <= 1'b0;
      r_fetch_pc <= '0;
      r_inst_pc  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bus_req  <= w_req_nx;
      r_bus_addr <= w_addr_nx;
      r_pend_err <= w_pend_nx;
      r_addr_err <= bus.flush && w_odd;
      if (bus.flush) begin
        r_fetch_en <= !w_odd;
        r_fetch_pc <= bus.flush_pc;
        r_inst_pc  <= bus.flush_pc;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_ack_acc) begin
          r_wr_ptr   <= r_wr_ptr + PW'(1);
          r_fetch_pc <= r_fetch_pc + 24'd2;
        end
        r_rd_ptr  <= r_rd_ptr + PW'(w_cons_amt);
        r_inst_pc <= r_inst_pc + {21'd0, w_cons_amt, 1'b0};
        r_count   <= r_count + CW'(w_ack_acc) - CW'(w_cons_amt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_L && w_ack_acc) r_mem[r_wr_ptr] <= bus.bus_data;
  end

  assign bus.bus_req    = r_bus_req;
  assign bus.bus_addr   = {r_bus_addr[23:1], 1'b0};
  assign bus.inst_valid = (r_count != '0);
  assign bus.ext_valid  = (r_count > CW'(1));
  assign bus.inst       = bus.inst_valid ? r_mem[r_rd_ptr] : 16'd0;
  assign bus.ext        = bus.ext_valid ? r_mem[w_ext_ptr] : 16'd0;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.addr_err   = r_addr_err;
  assign o_state        = r_state;
  assign o_count        = r_count;
endmodule
